// File: rtl/mem_common.sv
// mem_common: shared memory-request types used by the instruction-side
// front end, the icache and the request arbiter sitting between them.
//   t_mem_req   : request  {valid, id, addr}
//   t_mem_rsp   : response {valid, id, data}
//   t_arb_src   : which requester owns an outstanding cache id
//   t_arb_entry : one slot of the arbiter's outstanding-id table
package mem_common;

    localparam int MEM_ID_W   = 4;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [MEM_ID_W-1:0]   id;
        logic [MEM_ADDR_W-1:0] addr;
    } t_mem_req;

    typedef struct packed {
        logic                  valid;
        logic [MEM_ID_W-1:0]   id;
        logic [MEM_DATA_W-1:0] data;
    } t_mem_rsp;

    typedef enum logic {
        ARB_SRC_FB = 1'b0,
        ARB_SRC_PF = 1'b1
    } t_arb_src;

    typedef struct packed {
        logic                valid;
        t_arb_src            src;
        logic                squash;
        logic [MEM_ID_W-1:0] orig_id;
    } t_arb_entry;

endpackage

// File: rtl/ic_arb_idtbl.sv
// ic_arb_idtbl: table of outstanding icache ids for ic_arb.
// Each entry remembers which requester issued it, the requester's own id,
// and whether a front-end flush has squashed it.
//   clk, reset_n     : clock, asynchronous active-low reset
//   alloc            : write a new entry at alloc_idx this cycle
//   alloc_src        : owner of the new entry
//   alloc_orig_id    : requester id to restore on the response
//   free, free_idx   : release entry free_idx (cache response seen)
//   flush            : squash every valid demand (FB) entry
//   full             : no free entry this cycle
//   alloc_idx        : lowest free entry index, zero-extended to id width
//   empty_next       : no entry will be valid next cycle
//   entries          : registered table contents
module ic_arb_idtbl
    import mem_common::*;
#(
    parameter int NUM_IDS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     alloc,
    input  t_arb_src                 alloc_src,
    input  logic [MEM_ID_W-1:0]      alloc_orig_id,
    input  logic                     free,
    input  logic [MEM_ID_W-1:0]      free_idx,
    input  logic                     flush,
    output logic                     full,
    output logic [MEM_ID_W-1:0]      alloc_idx,
    output logic                     empty_next,
    output t_arb_entry [NUM_IDS-1:0] entries
);

    localparam int IDX_W = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;

    t_arb_entry [NUM_IDS-1:0] entries_q;
    t_arb_entry [NUM_IDS-1:0] entries_d;
    logic       [IDX_W-1:0]   alloc_sel;
    logic       [IDX_W-1:0]   free_sel;
    logic                     found;

    assign free_sel  = free_idx[IDX_W-1:0];
    assign alloc_idx = MEM_ID_W'(alloc_sel);
    assign full      = !found;
    assign entries   = entries_q;

    // Lowest-index free entry, taken from the registered valid bits only, so
    // an entry released this cycle is not reusable until the next one.
    always_comb begin
        found     = 1'b0;
        alloc_sel = '0;
        for (int unsigned i = 0; i < NUM_IDS; i++) begin
            if (!found && !entries_q[i].valid) begin
                found     = 1'b1;
                alloc_sel = IDX_W'(i);
            end
        end
    end

    // Free and allocate always touch different entries (free targets a valid
    // entry, alloc a free one), so their order here does not matter.
    always_comb begin
        entries_d = entries_q;
        if (flush) begin
            for (int unsigned i = 0; i < NUM_IDS; i++) begin
                if (entries_q[i].valid && entries_q[i].src == ARB_SRC_FB) begin
                    entries_d[i].squash = 1'b1;
                end
            end
        end
        if (free) begin
            entries_d[free_sel] = '0;
        end
        if (alloc) begin
            entries_d[alloc_sel] = '{valid: 1'b1, src: alloc_src,
                                     squash: 1'b0, orig_id: alloc_orig_id};
        end
    end

    always_comb begin
        empty_next = 1'b1;
        for (int unsigned i = 0; i < NUM_IDS; i++) begin
            if (entries_d[i].valid) begin
                empty_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/ic_arb.sv
// ic_arb: shares the icache's single request port between the fetch buffer
// (demand, FB) and the next-line prefetcher (PF). Requester ids are remapped
// onto a small table of outstanding cache ids; each cache response is steered
// back to its owner with the original id restored. A front-end flush squashes
// outstanding demand responses.
//   clk, reset_n    : clock, asynchronous active-low reset
//   fb_arb_req_nnn  : demand request in;   arb_fb_gnt_nnn : demand accepted
//   pf_arb_req_nnn  : prefetch request in; arb_pf_gnt_nnn : prefetch accepted
//   flush_nnn       : front-end redirect, squash outstanding demand
//   arb_ic_req_nnn  : registered request to icache (id = table index)
//   ic_arb_rsp_nnn  : response from icache
//   arb_fb_rsp_nnn  : demand response, original id restored
//   arb_pf_rsp_nnn  : prefetch response, original id restored
//   arb_idle_nnn    : registered; no entry valid and no issue pending
module ic_arb
    import mem_common::*;
#(
    parameter int NUM_IDS    = 4,
    parameter int STARVE_MAX = 3,
    parameter int LATENCY    = 1
) (
    input  logic     clk,
    input  logic     reset_n,
    input  t_mem_req fb_arb_req_nnn,
    output logic     arb_fb_gnt_nnn,
    input  t_mem_req pf_arb_req_nnn,
    output logic     arb_pf_gnt_nnn,
    input  logic     flush_nnn,
    output t_mem_req arb_ic_req_nnn,
    input  t_mem_rsp ic_arb_rsp_nnn,
    output t_mem_rsp arb_fb_rsp_nnn,
    output t_mem_rsp arb_pf_rsp_nnn,
    output logic     arb_idle_nnn
);

    localparam int IDX_W = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;
    localparam int SC_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic                     tbl_full;
    logic [MEM_ID_W-1:0]      tbl_alloc_idx;
    logic                     tbl_empty_next;
    t_arb_entry [NUM_IDS-1:0] tbl_entries;

    logic                     can_grant;
    logic                     pf_priority;
    logic                     grant;
    t_arb_src                 win_src;
    logic [MEM_ID_W-1:0]      win_id;
    logic [MEM_ADDR_W-1:0]    win_addr;
    logic [SC_W-1:0]          starve_cnt;

    logic                     rsp_idx_ok;
    logic [IDX_W-1:0]         rsp_sel;
    t_arb_entry               rsp_ent;
    logic                     rsp_hit;
    logic                     rsp_fwd;

    // ---------------------------------------------------------------- arbitration
    // Reset gates the grants so every output reads 0 while reset_n is low.
    assign can_grant   = reset_n && !tbl_full && !flush_nnn;
    assign pf_priority = (starve_cnt == SC_W'(STARVE_MAX)) && pf_arb_req_nnn.valid;

    assign arb_fb_gnt_nnn = can_grant && fb_arb_req_nnn.valid && !pf_priority;
    assign arb_pf_gnt_nnn = can_grant && pf_arb_req_nnn.valid &&
                            (pf_priority || !fb_arb_req_nnn.valid);
    assign grant          = arb_fb_gnt_nnn || arb_pf_gnt_nnn;

    assign win_src  = arb_pf_gnt_nnn ? ARB_SRC_PF : ARB_SRC_FB;
    assign win_id   = arb_pf_gnt_nnn ? pf_arb_req_nnn.id   : fb_arb_req_nnn.id;
    assign win_addr = arb_pf_gnt_nnn ? pf_arb_req_nnn.addr : fb_arb_req_nnn.addr;

    // ---------------------------------------------------------------- id table
    assign rsp_idx_ok = int'(ic_arb_rsp_nnn.id) < NUM_IDS;
    assign rsp_sel    = ic_arb_rsp_nnn.id[IDX_W-1:0];
    assign rsp_ent    = tbl_entries[rsp_sel];
    assign rsp_hit    = ic_arb_rsp_nnn.valid && rsp_idx_ok && rsp_ent.valid;
    // Squash is read from the registered table, so a response arriving in the
    // flush cycle itself is still delivered.
    assign rsp_fwd    = rsp_hit && !rsp_ent.squash;

    ic_arb_idtbl #(
        .NUM_IDS (NUM_IDS)
    ) u_idtbl (
        .clk           (clk),
        .reset_n       (reset_n),
        .alloc         (grant),
        .alloc_src     (win_src),
        .alloc_orig_id (win_id),
        .free          (rsp_hit),
        .free_idx      (ic_arb_rsp_nnn.id),
        .flush         (flush_nnn),
        .full          (tbl_full),
        .alloc_idx     (tbl_alloc_idx),
        .empty_next    (tbl_empty_next),
        .entries       (tbl_entries)
    );

    // ---------------------------------------------------------------- steering
    always_comb begin
        arb_fb_rsp_nnn = '0;
        arb_pf_rsp_nnn = '0;
        if (rsp_fwd) begin
            if (rsp_ent.src == ARB_SRC_FB) begin
                arb_fb_rsp_nnn = '{valid: 1'b1, id: rsp_ent.orig_id,
                                   data: ic_arb_rsp_nnn.data};
            end else begin
                arb_pf_rsp_nnn = '{valid: 1'b1, id: rsp_ent.orig_id,
                                   data: ic_arb_rsp_nnn.data};
            end
        end
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt     <= '0;
            arb_ic_req_nnn <= '0;
            arb_idle_nnn   <= 1'b1;
        end else begin
            // Counts demand wins while prefetch waits; any cycle with no
            // prefetch pending restarts the count.
            if (!pf_arb_req_nnn.valid || arb_pf_gnt_nnn) begin
                starve_cnt <= '0;
            end else if (arb_fb_gnt_nnn && starve_cnt != SC_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end

            if (grant) begin
                arb_ic_req_nnn <= '{valid: 1'b1, id: tbl_alloc_idx, addr: win_addr};
            end else begin
                arb_ic_req_nnn <= '0;
            end

            arb_idle_nnn <= tbl_empty_next && !grant;
        end
    end

    // ---------------------------------------------------------------- checks
    always_ff @(posedge clk) begin
        assert (LATENCY >= 1 && STARVE_MAX >= 1 && NUM_IDS >= 1 &&
                NUM_IDS <= (1 << MEM_ID_W))
            else $error("ic_arb: illegal parameter set");
        if (reset_n && ic_arb_rsp_nnn.valid) begin
            assert (rsp_hit)
                else $warning("ic_arb: response id %0d has no outstanding entry, dropped",
                              ic_arb_rsp_nnn.id);
        end
    end

endmodule

// File: doc/ic_arb.md
# ic_arb

Request arbiter and ID scheduler in front of the instruction cache's single request port. It shares that port between two requesters: the fetch buffer (demand) and a next-line prefetcher. It remaps requester IDs onto a small table of outstanding cache IDs and steers each cache response back to its owner. It also squashes in-flight demand responses on a front-end flush. Sits between the fetch buffer/prefetcher and `icache`; the cache has no backpressure, fixed latency, one request per cycle.

## Interface
- `NUM_IDS`, 4: outstanding cache requests tracked; must be ≤ 2^(width of `t_mem_req.id`).
- `STARVE_MAX`, 3: consecutive lost arbitrations after which prefetch wins.
- `LATENCY`, 1: cache latency; must equal the `icache` instance's `LATENCY`; used by assertions only.

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset; asynchronous, active-low
- `fb_arb_req_nnn`  in  `t_mem_req`  demand request (valid, id, addr)
- `arb_fb_gnt_nnn`  out  1  demand accepted this cycle
- `pf_arb_req_nnn`  in  `t_mem_req`  prefetch request
- `arb_pf_gnt_nnn`  out  1  prefetch accepted this cycle
- `flush_nnn`  in  1  front-end redirect; squash outstanding demand
- `arb_ic_req_nnn`  out  `t_mem_req`  request to `icache`
- `ic_arb_rsp_nnn`  in  `t_mem_rsp`  response from `icache`
- `arb_fb_rsp_nnn`  out  `t_mem_rsp`  demand response, original id restored
- `arb_pf_rsp_nnn`  out  `t_mem_rsp`  prefetch response, original id restored
- `arb_idle_nnn`  out  1  no entry valid and no issue pending

## Operation
- ID table: `NUM_IDS` entries of {valid, src, squash, orig_id}. Allocation takes the lowest-index free entry, computed from the registered valid vector.
- Handshake: requester holds valid/id/addr stable until gnt. Transfer occurs when valid & gnt. gnt is combinational from the current req valids and the table state.
- Arbitration: no grant when the table is full or `flush_nnn` is high. Otherwise:
  - If `starve_cnt == STARVE_MAX` and PF is valid, PF wins.
  - Else FB wins if valid, else PF.
  - At most one grant per cycle.
- `starve_cnt`:
  - Increments when PF is valid and FB is granted.
  - Clears on a PF grant or when PF is not valid.
  - Holds otherwise, including table-full and flush cycles.
  - Saturates at `STARVE_MAX`.
- Issue: on a grant, write the entry {1, src, 0, req.id} and register `arb_ic_req_nnn` = {valid=1, id=entry index zero-extended, addr}.
- Response: `ic_arb_rsp_nnn.valid` selects entry `rsp.id`.
  - Entry valid & !squash: forward data to its src's output with id = orig_id; the other output has valid=0.
  - Entry valid & squash: forward nothing.
  - Entry freed in both cases.
  - Entry not valid: drop, and a simulation assertion fires.
- Flush: every valid entry with src=FB gets squash=1. A demand request presented during flush is not granted. PF entries are unaffected.
- Reset: table cleared, `starve_cnt` = 0, all outputs 0 (valid fields 0, `arb_idle_nnn` = 1). Cache responses arriving after release hit invalid entries and are dropped.

## Timing
- Grant cycle N → `arb_ic_req_nnn.valid` at N+1 → cache response at N+1+`LATENCY`. Requester output is combinational in that same cycle, so total latency is `LATENCY`+1 from grant.
- An entry freed in cycle M becomes allocatable at M+1.
- Freeing and allocating in the same cycle are independent: a different free entry may be granted at M.
- `arb_idle_nnn` is registered: high the cycle after the last entry frees with no grant.
- Flush and a response to a FB entry in the same cycle: the response is still forwarded, because squash takes effect from the next cycle.

## Structure
- Add to `mem_common`: `t_arb_src` enum {`ARB_SRC_FB`, `ARB_SRC_PF`} and `t_arb_entry` struct.
- Sub-module `ic_arb_idtbl`: holds the entry array, lowest-free allocation, free on response, flush-squash; outputs `full` and the alloc index.
- `ic_arb` holds arbitration, `starve_cnt`, the issue flop and response steering.

## Test plan
- Single demand, `LATENCY`=1: FB id=5 addr=0x40 at cycle 0 → gnt cycle 0; `arb_ic_req_nnn` id=0 at cycle 1; `arb_fb_rsp_nnn` id=5 with cache data at cycle 2; idle at cycle 3.
- Contention, `STARVE_MAX`=3, both requesters always valid, `LATENCY`=1: grant order FB,FB,FB,PF repeating; at most one gnt per cycle.
- Full table, `LATENCY`=8, FB always valid: grants at cycles 0–3 (ids 0–3); none at 4–9; first response at cycle 9; next grant at cycle 10 reuses id 0.
- Flush, `LATENCY`=4: FB grants at cycles 0 and 1, PF grant at cycle 2, flush at cycle 3 → no `arb_fb_rsp_nnn` valid; `arb_pf_rsp_nnn` valid at cycle 7; `arb_idle_nnn`=1 at cycle 8.
- Reset mid-flight: 3 entries outstanding, `reset_n` pulsed low for 1 cycle → outputs 0 immediately; stale cache responses for ids 0–2 are dropped with no forwarding; the next FB request gets id 0.
- Injected response for an unallocated id 2 → both response outputs stay invalid, the assertion fires, and table state is unchanged.
